sm_input_debounce: RTL and testbench
====================================

// Module: sm_input_debounce
// PURPOSE
//  Conditions raw board inputs (KEY buttons, SW switches) before they reach the
//  core top (rst_n excluded). Provides a 2-FF synchronizer and a counter-based
//  debouncer per bit. Outputs clean levels plus one-cycle press/release pulses,
//  so clkEnable/step and regAddr never see metastability or contact bounce.
// PARAMETERS
//  WIDTH          6      number of input bits conditioned independently
//  IDLE_VAL       6'h3F  per-bit released level (KEY idle high); level reset value
//  TICK_DIV       50000  clk cycles per debounce tick (1 ms @ 50 MHz), >=1
//  DEBOUNCE_TICKS 10     consecutive ticks of stable differing input to accept, >=1
//  REPEAT_DELAY   500    ticks held before first auto-repeat (macro only)
//  REPEAT_RATE    100    ticks between auto-repeat pulses (macro only)
// PORTS
//  clk      in   1      single system clock; all state on posedge
//  rst_n    in   1      asynchronous active-low reset
//  in_raw   in   WIDTH  asynchronous raw inputs
//  level    out  WIDTH  debounced level
//  press    out  WIDTH  1-cycle pulse when level leaves IDLE_VAL (and on repeats)
//  release  out  WIDTH  1-cycle pulse when level returns to IDLE_VAL
//  tick     out  1      prescaler strobe, exported for test/observation
// BEHAVIOUR
//  - Reset (async, rst_n=0): sync FFs <= IDLE_VAL, level <= IDLE_VAL, all
//    counters <= 0, press/release/tick <= 0. Deassertion sync is handled by caller.
//  - Prescaler: pcnt 0..TICK_DIV-1, wraps to 0; tick=1 for exactly the cycle
//    where pcnt==TICK_DIV-1 (registered). TICK_DIV=1 -> tick every cycle.
//  - Sync: s1<=in_raw, s2<=s1; s2 is the only value the debouncer uses.
//  - Per bit i (fully independent, no shared state except tick):
//    s2[i]==level[i]            -> dcnt[i]<=0 (bounce resets the count)
//    s2[i]!=level[i] & !tick    -> hold dcnt[i]
//    s2[i]!=level[i] & tick & dcnt[i]<DEBOUNCE_TICKS-1 -> dcnt[i]+1
//    s2[i]!=level[i] & tick & dcnt[i]==DEBOUNCE_TICKS-1 -> level[i]<=s2[i],
//      dcnt[i]<=0, and in the same registered update press[i]<=1 if new level
//      !=IDLE_VAL[i], else release[i]<=1
//  - press/release are registered, high exactly one cycle, coincident with the
//    first cycle of the new level; never both high for the same bit.
//  - Latency for a clean edge: 2 + d + (DEBOUNCE_TICKS-1)*TICK_DIV + 1 cycles,
//    where d in [0,TICK_DIV-1] is the phase to the next tick.
//  - Counter width: dcnt = $clog2(DEBOUNCE_TICKS+1) bits, so it never wraps.
//  - Simultaneous edges on several bits -> pulses in the same cycle when their
//    counts complete together; no priority.
//  - Reset mid-count: state is discarded and level returns to IDLE_VAL; no
//    pulse is emitted for the aborted transition or on reset exit.
// CONFIGURATION
//  SM_DEBOUNCE_AUTOREPEAT_EN defined: per-bit rcnt counts ticks while
//    level[i]!=IDLE_VAL[i]; extra press[i] pulse when rcnt reaches
//    REPEAT_DELAY, then every REPEAT_RATE ticks after; rcnt clears on release
//    or reset. Repeat pulses are 1 cycle, aligned to the cycle after tick.
//  Not defined: no rcnt logic; exactly one press per accepted transition.
// TESTING  (WIDTH=2, IDLE_VAL=2'b11, TICK_DIV=4, DEBOUNCE_TICKS=3)
//  1 rst_n=0 with in_raw=2'b00 -> level=2'b11, press=release=0; after
//    rst_n=1, level[1:0] fall 11-14 cycles later with press=2'b11 for 1 cycle.
//  2 in_raw[0] 1->0 clean -> level[0]=0 11-14 cycles after edge; press[0]
//    high 1 cycle; level[1], press[1], and release stay idle.
//  3 in_raw[0] toggles every 3 cycles for 30 cycles then holds 0 -> level[0]
//    unchanged during bounce; falls 11-14 cycles after last edge; 1 press only.
//  4 in_raw[0] back to 1 -> release[0] 1 cycle, 11-14 cycles after edge.
//  5 rst_n=0 after dcnt[0] reaches 2, then released with in_raw idle ->
//    level=2'b11, no press/release pulses seen after reset.
//  6 SM_DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold in_raw[0]=0 ->
//    press at accept, again 5 ticks later, then every 8 cycles; without the
//    macro exactly one press.

Source files
------------

// File: rtl/sm_input_debounce_if.sv
// Board-input conditioning bus: raw asynchronous inputs in, clean levels and pulses out.
// The release strobe is carried on release_pulse because "release" is a reserved word.
interface sm_input_debounce_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] in_raw;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] release_pulse;
  logic             tick;

  modport master (output in_raw, input level, press, release_pulse, tick);
  modport slave  (input in_raw, output level, press, release_pulse, tick);
endinterface

// File: rtl/sm_input_debounce.sv
// Per-bit 2-FF synchronizer plus tick-counted debouncer with press/release strobes.
// Optional auto-repeat of press while held: define SM_DEBOUNCE_AUTOREPEAT_EN.
module sm_input_debounce #(
  parameter int               WIDTH          = 6,
  parameter logic [WIDTH-1:0] IDLE_VAL       = {WIDTH{1'b1}},
  parameter int               TICK_DIV       = 50000,
  parameter int               DEBOUNCE_TICKS = 10,
  parameter int               REPEAT_DELAY   = 500,
  parameter int               REPEAT_RATE    = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  sm_input_debounce_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_TICKS - 1);

  // An out-of-range setting shows up as g_cfg_invalid in the elaborated hierarchy.
  if (TICK_DIV < 1 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_invalid
  end

  logic [PW-1:0]    pcnt_reg, pcnt_next;
  logic             tick_reg, tick_next;
  logic [WIDTH-1:0] s1_reg, s2_reg;
  logic [WIDTH-1:0] level_vec, press_vec, release_vec;

  // tick is registered so it is high exactly while pcnt_reg sits at TICK_DIV-1
  always_comb begin
    pcnt_next = (pcnt_reg == PCNT_LAST) ? '0 : pcnt_reg + 1'b1;
    tick_next = (pcnt_next == PCNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
      tick_reg <= 1'b0;
      s1_reg   <= IDLE_VAL;
      s2_reg   <= IDLE_VAL;
    end else begin
      pcnt_reg <= pcnt_next;
      tick_reg <= tick_next;
      s1_reg   <= bus.in_raw;
      s2_reg   <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [DW-1:0] dcnt_reg, dcnt_next;
      logic          level_reg, level_next;
      logic          press_reg, press_next;
      logic          release_reg, release_next;
      logic          repeat_hit;

      always_comb begin
        dcnt_next    = dcnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (s2_reg[gi] == level_reg) begin
          dcnt_next = '0;
        end else if (tick_reg) begin
          if (dcnt_reg == DCNT_LAST) begin
            dcnt_next  = '0;
            level_next = s2_reg[gi];
            if (s2_reg[gi] != IDLE_VAL[gi]) begin
              press_next = 1'b1;
            end else begin
              release_next = 1'b1;
            end
          end else begin
            dcnt_next = dcnt_reg + 1'b1;
          end
        end
      end

`ifdef SM_DEBOUNCE_AUTOREPEAT_EN
      localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
      logic [RW-1:0] rcnt_reg, rcnt_next;

      // Counts ticks spent held; after the first repeat it reloads to REPEAT_DELAY
      always_comb begin
        rcnt_next  = rcnt_reg;
        repeat_hit = 1'b0;
        if ((level_next != level_reg) || (level_reg == IDLE_VAL[gi])) begin
          rcnt_next = '0;
        end else if (tick_reg) begin
          rcnt_next = rcnt_reg + 1'b1;
          if (rcnt_next == RW'(REPEAT_DELAY)) begin
            repeat_hit = 1'b1;
          end else if (rcnt_next == RW'(REPEAT_DELAY + REPEAT_RATE)) begin
            repeat_hit = 1'b1;
            rcnt_next  = RW'(REPEAT_DELAY);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_reg <= '0;
        end else begin
          rcnt_reg <= rcnt_next;
        end
      end
`else
      assign repeat_hit = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dcnt_reg    <= '0;
          level_reg   <= IDLE_VAL[gi];
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          dcnt_reg    <= dcnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next | repeat_hit;
          release_reg <= release_next;
        end
      end

      assign level_vec[gi]   = level_reg;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;
    end
  endgenerate

  assign bus.level         = level_vec;
  assign bus.press         = press_vec;
  assign bus.release_pulse = release_vec;
  assign bus.tick          = tick_reg;
endmodule

// File: tb/tb_sm_input_debounce.sv
// Scoreboard bench for sm_input_debounce: model predicts pulses, monitor pops and compares.
`timescale 1ns/1ps
module tb_sm_input_debounce;
  localparam int         W    = 2;
  localparam logic [1:0] IDLE = 2'b11;
  localparam int         TD   = 4;
  localparam int         DT   = 3;
  localparam int         RD   = 5;
  localparam int         RR   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_input_debounce_if #(.WIDTH(W)) bus ();

  sm_input_debounce #(
    .WIDTH(W), .IDLE_VAL(IDLE), .TICK_DIV(TD), .DEBOUNCE_TICKS(DT),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  ev_t        exp_q[$];
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         press_cnt0 = 0;
  logic [1:0] m_level   = IDLE;

  // Reference: a bit accepts a new value once the synchronized input has differed
  // from the level across DT consecutive ticks; ticks fall on cycles where cyc%TD==TD-1.
  initial begin : model
    logic [1:0] hist[$];
    logic [1:0] seen;
    logic [1:0] idle_v;
    int         diff_ticks[W];
    int         held[W];
    bit         tick_now;
    bit         acc;
    ev_t        ev;
    idle_v = IDLE;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc     = 0;
        m_level = IDLE;
        hist    = '{IDLE, IDLE};
        for (int b = 0; b < W; b++) begin
          diff_ticks[b] = 0;
          held[b]       = 0;
        end
      end else begin
        seen     = hist[0];
        tick_now = (cyc % TD) == (TD - 1);
        ev.cyc   = cyc + 1;
        ev.press = 2'b00;
        ev.rel   = 2'b00;
        for (int b = 0; b < W; b++) begin
          if (seen[b] != m_level[b]) begin
            if (tick_now) diff_ticks[b]++;
          end else begin
            diff_ticks[b] = 0;
          end
          acc = (diff_ticks[b] == DT);
          if (acc) begin
            diff_ticks[b] = 0;
            held[b]       = 0;
            if (seen[b] != idle_v[b]) ev.press[b] = 1'b1;
            else                      ev.rel[b]   = 1'b1;
            m_level[b] = seen[b];
          end else if (m_level[b] != idle_v[b]) begin
`ifdef SM_DEBOUNCE_AUTOREPEAT_EN
            if (tick_now) begin
              held[b]++;
              if (held[b] >= RD && ((held[b] - RD) % RR) == 0) ev.press[b] = 1'b1;
            end
`endif
          end else begin
            held[b] = 0;
          end
        end
        if ((ev.press | ev.rel) != 2'b00) exp_q.push_back(ev);
        void'(hist.pop_front());
        hist.push_back(bus.in_raw);
        cyc++;
      end
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.press != 2'b00 || bus.release_pulse != 2'b00) begin
        if (bus.press[0]) press_cnt0++;
        checks++;
        if ((bus.press & bus.release_pulse) != 2'b00) begin
          errors++;
          $display("FAIL both_pulses cyc=%0d press=%b release=%b required disjoint",
                   cyc, bus.press, bus.release_pulse);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b required none",
                   cyc, bus.press, bus.release_pulse);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.press != bus.press || e.rel != bus.release_pulse) begin
            errors++;
            $display("FAIL pulse cyc=%0d press=%b release=%b required cyc=%0d press=%b release=%b",
                     cyc, bus.press, bus.release_pulse, e.cyc, e.press, e.rel);
          end else begin
            $display("pulse cyc=%0d press=%b release=%b level=%b ok",
                     cyc, bus.press, bus.release_pulse, bus.level);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d required press=%b release=%b at cyc=%0d",
                 cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end else begin
      $display("%s value=%b ok", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("%s value=%0d ok", name, act);
    end
  endtask

  // Waits (bounded) for a level bit to take val; latency measured from edge_cyc.
  task automatic wait_level(input string name, input int bitn, input logic val, input int edge_cyc);
    int waited = 0;
    int lat;
    while (bus.level[bitn] !== val && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    lat = cyc - edge_cyc;
    if (bus.level[bitn] !== val) begin
      errors++;
      $display("FAIL %s timeout level[%0d]=%b required %b", name, bitn, bus.level[bitn], val);
    end else if (lat < 11 || lat > 14) begin
      errors++;
      $display("FAIL %s latency actual=%0d required 11..14", name, lat);
    end else begin
      $display("%s level[%0d]=%b after %0d cycles ok", name, bitn, val, lat);
    end
  endtask

  initial begin : stim
    int edge_c;
    int p0;
    int hold[W];
    logic [1:0] nv;
    bus.in_raw = 2'b00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t1_reset_level", bus.level, 2'b11);
    check_eq("t1_reset_press", bus.press, 2'b00);
    check_eq("t1_reset_release", bus.release_pulse, 2'b00);
    rst_n  = 1'b1;
    edge_c = cyc;
    wait_level("t1_fall0", 0, 1'b0, edge_c);
    check_eq("t1_press", bus.press, 2'b11);
    wait_level("t1_fall1", 1, 1'b0, edge_c);
    @(negedge clk);
    check_eq("t1_press_one_cycle", bus.press, 2'b00);

    bus.in_raw = 2'b11;
    edge_c     = cyc;
    wait_level("t1_rise0", 0, 1'b1, edge_c);
    check_eq("t1_release", bus.release_pulse, 2'b11);
    repeat (5) @(negedge clk);

    bus.in_raw = 2'b10;
    edge_c     = cyc;
    wait_level("t2_fall0", 0, 1'b0, edge_c);
    check_eq("t2_press", bus.press, 2'b01);
    check_eq("t2_release", bus.release_pulse, 2'b00);
    check_eq("t2_level", bus.level, 2'b10);
    repeat (5) @(negedge clk);

    bus.in_raw = 2'b11;
    edge_c     = cyc;
    wait_level("t4_rise0", 0, 1'b1, edge_c);
    check_eq("t4_release", bus.release_pulse, 2'b01);
    repeat (5) @(negedge clk);

    p0 = press_cnt0;
    for (int i = 0; i < 10; i++) begin
      bus.in_raw[0] = ~bus.in_raw[0];
      repeat (3) @(negedge clk);
    end
    check_eq("t3_bounce_level", bus.level, 2'b11);
    bus.in_raw = 2'b10;
    edge_c     = cyc;
    wait_level("t3_fall0", 0, 1'b0, edge_c);
    repeat (5) @(negedge clk);
    check_int("t3_single_press", press_cnt0 - p0, 1);
    bus.in_raw = 2'b11;
    edge_c     = cyc;
    wait_level("t3_rise0", 0, 1'b1, edge_c);
    repeat (5) @(negedge clk);

    p0         = press_cnt0;
    bus.in_raw = 2'b10;
    repeat (10) @(negedge clk);
    rst_n      = 1'b0;
    bus.in_raw = 2'b11;
    repeat (2) @(negedge clk);
    check_eq("t5_reset_level", bus.level, 2'b11);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("t5_after_level", bus.level, 2'b11);
    check_int("t5_no_press", press_cnt0 - p0, 0);

    p0         = press_cnt0;
    bus.in_raw = 2'b10;
    edge_c     = cyc;
    wait_level("t6_fall0", 0, 1'b0, edge_c);
    repeat (50) @(negedge clk);
`ifdef SM_DEBOUNCE_AUTOREPEAT_EN
    check_int("t6_press_count", press_cnt0 - p0, 5);
`else
    check_int("t6_press_count", press_cnt0 - p0, 1);
`endif
    bus.in_raw = 2'b11;
    edge_c     = cyc;
    wait_level("t6_rise0", 0, 1'b1, edge_c);
    repeat (5) @(negedge clk);

    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      nv = bus.in_raw;
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          nv[b]   = ~nv[b];
          hold[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 60);
        end else begin
          hold[b]--;
        end
      end
      bus.in_raw = nv;
      @(negedge clk);
      if ((c % 16) == 15) check_eq("rand_level", bus.level, m_level);
    end

    bus.in_raw = 2'b11;
    repeat (40) @(negedge clk);
    check_eq("final_level", bus.level, 2'b11);
    check_int("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
